matrix_tile_loader: RTL and testbench

Upstream feeder for `matrix_transpose_top`. It accepts a row-major element stream over a valid/ready handshake and assembles each `NUM_MG` x `NUM_PE` tile in a ping-pong pair of tile buffers. It presents completed tiles as `input_elements` with `in_val`, together with `base_addr` and a per-tile `chunk_addr`. One tile can fill while the other is held for the transpose.

---
 rtl/matrix_transpose_pkg.sv | 26 ++
 rtl/matrix_tile_bank.sv | 32 +++
 rtl/matrix_tile_loader.sv | 209 ++++++++++++++++++++
 tb/tb_matrix_tile_loader.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_transpose_pkg.sv
// Shared types and helpers for the matrix transpose front end.
// Holds the loader state encoding and tile geometry helpers.
package matrix_transpose_pkg;

   localparam int DFLT_DATA_WIDTH = 64;
   localparam int DFLT_NUM_MG     = 16;
   localparam int DFLT_NUM_PE     = 16;

   typedef logic [DFLT_DATA_WIDTH-1:0] elem_t;
   typedef elem_t tile_t [DFLT_NUM_MG][DFLT_NUM_PE];

   typedef enum logic [1:0] {
      LD_IDLE   = 2'd0,
      LD_RUN    = 2'd1,
      LD_FINISH = 2'd2
   } ld_state_e;

   function automatic int unsigned tile_bytes(
      input int unsigned mg,
      input int unsigned pe,
      input int unsigned dw
   );
      return (mg * pe * dw) / 8;
   endfunction

endpackage

// File: rtl/matrix_tile_bank.sv
// One tile buffer: single element write port, whole-tile read port.
// Contents are intentionally not reset.
module matrix_tile_bank
   import matrix_transpose_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_MG     = 16,
   parameter int NUM_PE     = 16,
   parameter int ROW_W      = 4,
   parameter int COL_W      = 4
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [ROW_W-1:0]      i_row,
   input  logic [COL_W-1:0]      i_col,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0] o_tile [NUM_MG][NUM_PE]
);

   logic [DATA_WIDTH-1:0] r_mem [NUM_MG][NUM_PE];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_row][i_col] <= i_data;
      end
   end

   always_comb begin
      o_tile = r_mem;
   end

endmodule

// File: rtl/matrix_tile_loader.sv
// Row-major stream to tile assembler with ping-pong tile buffers.
// One bank fills while the other is held for the consumer.
module matrix_tile_loader
   import matrix_transpose_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_MG     = 16,
   parameter int NUM_PE     = NUM_MG,
   parameter int ADDR_WIDTH = 64,
   parameter int CHUNK_SIZE = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] job_base_addr,
   input  logic [CNT_WIDTH-1:0]  num_tiles,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] input_elements [NUM_MG][NUM_PE],
   output logic                  in_val,
   input  logic                  in_rdy,
   output logic [ADDR_WIDTH-1:0] base_addr,
   output logic [ADDR_WIDTH-1:0] chunk_addr,
   output logic                  busy,
   output logic                  done
);

   localparam int ROW_W = (NUM_MG > 1) ? $clog2(NUM_MG) : 1;
   localparam int COL_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_MG - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_PE - 1);
   localparam logic [ADDR_WIDTH-1:0] TILE_BYTES =
      ADDR_WIDTH'(tile_bytes(NUM_MG, NUM_PE, DATA_WIDTH));

   if ((NUM_MG * NUM_PE * DATA_WIDTH) % 8 != 0 || CHUNK_SIZE < 1) begin : g_param_check
      $error("matrix_tile_loader: tile must be whole bytes, CHUNK_SIZE positive");
   end

   ld_state_e             r_state;
   ld_state_e             w_next;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [ADDR_WIDTH-1:0] r_chunk;
   logic [CNT_WIDTH-1:0]  r_num_tiles;
   logic [CNT_WIDTH-1:0]  r_filled;
   logic [CNT_WIDTH-1:0]  r_sent;
   logic [ROW_W-1:0]      r_row;
   logic [COL_W-1:0]      r_col;
   logic [1:0]            r_full;
   logic [1:0]            w_full_nxt;
   logic                  r_wr_bank;
   logic                  r_rd_bank;

   logic w_run;
   logic w_busy;
   logic w_done;
   logic w_start;
   logic w_s_ready;
   logic w_acc;
   logic w_tile_done;
   logic w_in_val;
   logic w_hs;
   logic w_last_tile;

   logic [DATA_WIDTH-1:0] w_tile0 [NUM_MG][NUM_PE];
   logic [DATA_WIDTH-1:0] w_tile1 [NUM_MG][NUM_PE];

   assign w_start     = (r_state == LD_IDLE) && start;
   assign w_s_ready   = w_run && !r_full[r_wr_bank] && (r_filled < r_num_tiles);
   assign w_acc       = s_valid && w_s_ready;
   assign w_tile_done = w_acc && (r_row == ROW_LAST) && (r_col == COL_LAST);
   assign w_in_val    = r_full[r_rd_bank];
   assign w_hs        = w_in_val && in_rdy;
   assign w_last_tile = w_hs && (r_sent == r_num_tiles - CNT_WIDTH'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= LD_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_run  = 1'b0;
      w_busy = 1'b0;
      w_done = 1'b0;
      unique case (r_state)
         LD_IDLE: begin
            if (start) begin
               w_next = (num_tiles == '0) ? LD_FINISH : LD_RUN;
            end
         end
         LD_RUN: begin
            w_run  = 1'b1;
            w_busy = 1'b1;
            if (w_last_tile) begin
               w_next = LD_FINISH;
            end
         end
         LD_FINISH: begin
            w_done = 1'b1;
            w_next = LD_IDLE;
         end
         default: w_next = LD_IDLE;
      endcase
   end

   // Fill and drain always target different banks, so both may land at once.
   always_comb begin
      w_full_nxt = r_full;
      if (w_tile_done) begin
         w_full_nxt[r_wr_bank] = 1'b1;
      end
      if (w_hs) begin
         w_full_nxt[r_rd_bank] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_base      <= '0;
         r_chunk     <= '0;
         r_num_tiles <= '0;
         r_filled    <= '0;
         r_sent      <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_full      <= '0;
         r_wr_bank   <= 1'b0;
         r_rd_bank   <= 1'b0;
      end else if (w_start) begin
         r_base      <= job_base_addr;
         r_chunk     <= job_base_addr;
         r_num_tiles <= num_tiles;
         r_filled    <= '0;
         r_sent      <= '0;
         r_row       <= '0;
         r_col       <= '0;
      end else begin
         if (w_acc) begin
            if (r_col == COL_LAST) begin
               r_col <= '0;
               r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
            end else begin
               r_col <= r_col + COL_W'(1);
            end
         end
         if (w_tile_done) begin
            r_wr_bank <= ~r_wr_bank;
            r_filled  <= r_filled + CNT_WIDTH'(1);
         end
         if (w_hs) begin
            r_rd_bank <= ~r_rd_bank;
            r_sent    <= r_sent + CNT_WIDTH'(1);
            r_chunk   <= r_chunk + TILE_BYTES;
         end
         r_full <= w_full_nxt;
      end
   end

   matrix_tile_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_MG     (NUM_MG),
      .NUM_PE     (NUM_PE),
      .ROW_W      (ROW_W),
      .COL_W      (COL_W)
   ) u_bank0 (
      .clk    (clk),
      .i_we   (w_acc && !r_wr_bank),
      .i_row  (r_row),
      .i_col  (r_col),
      .i_data (s_data),
      .o_tile (w_tile0)
   );

   matrix_tile_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_MG     (NUM_MG),
      .NUM_PE     (NUM_PE),
      .ROW_W      (ROW_W),
      .COL_W      (COL_W)
   ) u_bank1 (
      .clk    (clk),
      .i_we   (w_acc && r_wr_bank),
      .i_row  (r_row),
      .i_col  (r_col),
      .i_data (s_data),
      .o_tile (w_tile1)
   );

   always_comb begin
      for (int r = 0; r < NUM_MG; r++) begin
         for (int c = 0; c < NUM_PE; c++) begin
            input_elements[r][c] = r_rd_bank ? w_tile1[r][c] : w_tile0[r][c];
         end
      end
   end

   assign s_ready    = w_s_ready;
   assign in_val     = w_in_val;
   assign base_addr  = r_base;
   assign chunk_addr = r_chunk;
   assign busy       = w_busy;
   assign done       = w_done;

endmodule

// File: tb/tb_matrix_tile_loader.sv
// Scoreboard bench for matrix_tile_loader on a 2x2 byte tile.
// Stimulus feeds a tile model; a negedge monitor checks every presented tile.
module tb_matrix_tile_loader;

   localparam int DW     = 8;
   localparam int MG     = 2;
   localparam int PE     = 2;
   localparam int AW     = 32;
   localparam int CW     = 16;
   localparam int NE     = MG * PE;
   localparam int TBYTES = MG * PE * DW / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] job_base_addr;
   logic [CW-1:0] num_tiles;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic [DW-1:0] input_elements [MG][PE];
   logic          in_val;
   logic          in_rdy;
   logic [AW-1:0] base_addr;
   logic [AW-1:0] chunk_addr;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   matrix_tile_loader #(
      .DATA_WIDTH (DW),
      .NUM_MG     (MG),
      .NUM_PE     (PE),
      .ADDR_WIDTH (AW),
      .CHUNK_SIZE (16),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .job_base_addr  (job_base_addr),
      .num_tiles      (num_tiles),
      .s_valid        (s_valid),
      .s_data         (s_data),
      .s_ready        (s_ready),
      .input_elements (input_elements),
      .in_val         (in_val),
      .in_rdy         (in_rdy),
      .base_addr      (base_addr),
      .chunk_addr     (chunk_addr),
      .busy           (busy),
      .done           (done)
   );

   typedef struct {
      logic [DW*NE-1:0] tile;
      logic [AW-1:0]    chunk;
      logic [AW-1:0]    base;
      bit               last;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   done_cnt    = 0;
   bit   exp_done    = 0;
   bit   zero_flag   = 0;
   bit   rnd_rdy     = 0;

   logic [AW-1:0]    m_base;
   int               m_n;
   int               m_idx;
   int               m_cnt;
   logic [DW*NE-1:0] m_buf;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW*NE-1:0] flat();
      logic [DW*NE-1:0] f;
      f = '0;
      for (int r = 0; r < MG; r++)
         for (int c = 0; c < PE; c++)
            f[DW*(r*PE+c) +: DW] = input_elements[r][c];
      return f;
   endfunction

   task automatic model_start(input logic [AW-1:0] b, input int n);
      m_base = b;
      m_n    = n;
      m_idx  = 0;
      m_cnt  = 0;
      m_buf  = '0;
   endtask

   // Element k of a tile lands at row k/PE, col k%PE.
   task automatic model_push(input logic [DW-1:0] d);
      exp_t e;
      m_buf[DW*m_cnt +: DW] = d;
      m_cnt++;
      if (m_cnt == NE) begin
         e.tile  = m_buf;
         e.chunk = m_base + AW'(m_idx * TBYTES);
         e.base  = m_base;
         e.last  = (m_idx == m_n - 1);
         sb.push_back(e);
         m_idx++;
         m_cnt = 0;
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (done || exp_done || zero_flag) begin
            chk("done", done, exp_done || zero_flag);
            if (done) chk("busy_at_done", busy, 0);
         end
         if (done) done_cnt++;
         exp_done  = 0;
         zero_flag = 0;
         if (in_val) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL spurious_tile: got %0h, want no tile at %0t", flat(), $time);
            end else begin
               chk("tile", flat(), sb[0].tile);
               chk("chunk_addr", chunk_addr, sb[0].chunk);
               chk("base_addr", base_addr, sb[0].base);
               if (in_rdy) begin
                  exp_done = sb[0].last;
                  void'(sb.pop_front());
               end
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rnd_rdy) begin
         #1 in_rdy = 1'($urandom_range(0, 1));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [AW-1:0] b, input int n);
      job_base_addr = b;
      num_tiles     = CW'(n);
      start         = 1'b1;
      model_start(b, n);
      cyc();
      start = 1'b0;
   endtask

   task automatic send_elem(input logic [DW-1:0] d, inout int stalls);
      bit acc;
      int waited;
      acc    = 0;
      waited = 0;
      s_valid = 1'b1;
      s_data  = d;
      while (!acc && waited < 200) begin
         @(negedge clk);
         acc = s_ready;
         cyc();
         if (!acc) begin
            waited++;
            stalls++;
         end
      end
      s_valid = 1'b0;
      if (acc) model_push(d);
      else begin
         vectors++;
         miscompares++;
         $display("FAIL stream_timeout: got no accept, want accept of %0h", d);
      end
   endtask

   task automatic send_rand(input int n, input int gap_pct);
      int st;
      st = 0;
      for (int i = 0; i < n; i++) begin
         send_elem(DW'($urandom), st);
         if ($urandom_range(0, 99) < gap_pct) cyc();
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 300);
      if (busy) begin
         vectors++;
         miscompares++;
         $display("FAIL done_timeout: got busy=1, want job completion");
      end
      cyc();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1);
   end

   initial begin
      int st;
      logic [DW-1:0] d;
      bit ok;
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
      in_rdy = 1'b0; job_base_addr = '0; num_tiles = '0;
      repeat (2) cyc();
      @(negedge clk);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_in_val", in_val, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_base", base_addr, 0);
      chk("rst_chunk", chunk_addr, 0);
      cyc();
      rst = 1'b0;
      cyc();

      // single tile, latency of in_val
      do_start(32'h100, 1);
      st = 0;
      for (int i = 1; i <= 4; i++) send_elem(DW'(i), st);
      @(negedge clk);
      chk("t1_inval_latency", in_val, 1);
      chk("t1_tile", flat(), 32'h04030201);
      cyc();
      in_rdy = 1'b1;
      wait_done();
      in_rdy = 1'b0;

      // back-to-back tiles with consumer always ready
      in_rdy = 1'b1;
      do_start(32'h100, 3);
      st = 0;
      for (int i = 0; i < 12; i++) send_elem(DW'($urandom), st);
      chk("t2_no_stall", st, 0);
      wait_done();
      in_rdy = 1'b0;

      // both banks full blocks the stream
      do_start(32'h200, 3);
      st = 0;
      for (int i = 0; i < 8; i++) send_elem(DW'($urandom), st);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_sready_low", s_ready, 0);
         cyc();
      end
      in_rdy = 1'b1;
      @(negedge clk);
      cyc();
      in_rdy = 1'b0;
      @(negedge clk);
      chk("t3_reopen", s_ready, 1);
      cyc();
      repeat (3) cyc();
      in_rdy = 1'b1;
      for (int i = 0; i < 4; i++) send_elem(DW'($urandom), st);
      wait_done();
      in_rdy = 1'b0;

      // fill completion and drain in the same cycle
      do_start(32'h500, 3);
      st = 0;
      for (int i = 0; i < 7; i++) send_elem(DW'($urandom), st);
      d = DW'($urandom);
      s_valid = 1'b1;
      s_data  = d;
      in_rdy  = 1'b1;
      @(negedge clk);
      ok = s_ready;
      chk("t4_sready", s_ready, 1);
      cyc();
      if (ok) model_push(d);
      s_valid = 1'b0;
      in_rdy  = 1'b0;
      @(negedge clk);
      chk("t4_inval", in_val, 1);
      chk("t4_sready_after", s_ready, 1);
      cyc();
      in_rdy = 1'b1;
      for (int i = 0; i < 4; i++) send_elem(DW'($urandom), st);
      wait_done();
      in_rdy = 1'b0;

      // random traffic, chunk address wraps past 2^AW
      rnd_rdy = 1'b1;
      do_start(32'hFFFF_FFF4, 8);
      send_rand(32, 30);
      wait_done();
      rnd_rdy = 1'b0;
      cyc();
      in_rdy = 1'b0;

      // reset mid-tile discards the partial tile
      do_start(32'h700, 2);
      st = 0;
      for (int i = 0; i < 3; i++) send_elem(DW'($urandom), st);
      rst = 1'b1;
      cyc();
      @(negedge clk);
      chk("t5_s_ready", s_ready, 0);
      chk("t5_in_val", in_val, 0);
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      chk("t5_base", base_addr, 0);
      chk("t5_chunk", chunk_addr, 0);
      cyc();
      rst = 1'b0;
      cyc();
      in_rdy = 1'b1;
      do_start(32'h100, 1);
      send_elem(8'd9, st);
      send_elem(8'd8, st);
      send_elem(8'd7, st);
      send_elem(8'd6, st);
      wait_done();
      in_rdy = 1'b0;

      // empty job, then start while busy
      do_start(32'h900, 0);
      zero_flag = 1'b1;
      @(negedge clk);
      chk("t6_zero_sready", s_ready, 0);
      chk("t6_zero_inval", in_val, 0);
      cyc();
      @(negedge clk);
      chk("t6_done_once", done, 0);
      cyc();
      do_start(32'h300, 1);
      st = 0;
      send_elem(DW'($urandom), st);
      send_elem(DW'($urandom), st);
      job_base_addr = 32'h400;
      num_tiles     = CW'(5);
      start         = 1'b1;
      cyc();
      start = 1'b0;
      send_elem(DW'($urandom), st);
      send_elem(DW'($urandom), st);
      @(negedge clk);
      chk("t6_base_kept", base_addr, 32'h300);
      chk("t6_chunk_kept", chunk_addr, 32'h300);
      cyc();
      in_rdy = 1'b1;
      wait_done();
      in_rdy = 1'b0;

      repeat (3) cyc();
      chk("sb_empty", sb.size(), 0);
      chk("done_count", done_cnt, 8);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
